// File: rtl/mult_controller.sv
// Sequencing FSM for a radix-2 shift-add multiplier: steers load/add/shift strobes of an
// external product datapath and reports busy/done plus the current iteration index.
module mult_controller #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mult_lsb,
    output logic             load,
    output logic             add_en,
    output logic             shift_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StTest,
        StAdd,
        StShift,
        StDone
    } state_t;

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
        end
    end

    // All strobes decode from the registered state alone, so reset clears them at once.
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        load         = 1'b0;
        add_en       = 1'b0;
        shift_en     = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        unique case (r_state)
            StIdle: begin
                busy = 1'b0;
                if (start) begin
                    w_state_next = StLoad;
                    w_count_next = '0;
                end
            end
            StLoad: begin
                load         = 1'b1;
                w_count_next = '0;
                w_state_next = StTest;
            end
            StTest: begin
                w_state_next = mult_lsb ? StAdd : StShift;
            end
            StAdd: begin
                add_en       = 1'b1;
                w_state_next = StShift;
            end
            StShift: begin
                shift_en = 1'b1;
                if (r_count == LastCnt) begin
                    w_state_next = StDone;
                end else begin
                    w_state_next = StTest;
                    w_count_next = r_count + 1'b1;
                end
            end
            StDone: begin
                done         = 1'b1;
                w_state_next = StIdle;
            end
            default: begin
                busy         = 1'b0;
                w_state_next = StIdle;
            end
        endcase
    end

    assign count = r_count;

endmodule

// File: tb/tb_mult_controller.sv
// Bench for mult_controller: a per-cycle expected-trace model driven by the operand bits,
// a reference shift-add datapath feeding mult_lsb, directed literal cases and random traffic.
module tb_mult_controller;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             mult_lsb = 1'b0;
    logic             load;
    logic             add_en;
    logic             shift_en;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] count;

    mult_controller #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mult_lsb(mult_lsb),
        .load    (load),
        .add_en  (add_en),
        .shift_en(shift_en),
        .busy    (busy),
        .done    (done),
        .count   (count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             load;
        logic             add_en;
        logic             shift_en;
        logic             busy;
        logic             done;
        logic [CNT_W-1:0] count;
        logic             is_test;
    } exp_t;

    exp_t             exp_q[$];
    exp_t             exp_cur = '0;
    exp_t             idle_e;
    logic [WIDTH-1:0] nxt_a = '0;
    logic [WIDTH-1:0] nxt_b = '0;
    logic [WIDTH-1:0] op_a = '0;
    logic [WIDTH-1:0] op_b = '0;
    logic [2*WIDTH:0] dp = '0;
    logic [63:0]      last_prod = '0;
    int               n_tests = 0;
    int               n_fail = 0;
    bit               noise_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expected cycle-by-cycle trace of one multiply, derived from the multiplier bits.
    function automatic void push_op(input logic [WIDTH-1:0] m);
        exp_t e;
        e = '0; e.busy = 1'b1; e.load = 1'b1;
        exp_q.push_back(e);
        for (int i = 0; i < int'(WIDTH); i++) begin
            e = '0; e.busy = 1'b1; e.count = CNT_W'(i); e.is_test = 1'b1;
            exp_q.push_back(e);
            e.is_test = 1'b0;
            if (m[i]) begin
                e.add_en = 1'b1;
                exp_q.push_back(e);
                e.add_en = 1'b0;
            end
            e.shift_en = 1'b1;
            exp_q.push_back(e);
        end
        e = '0; e.busy = 1'b1; e.done = 1'b1; e.count = CNT_W'(WIDTH - 1);
        exp_q.push_back(e);
    endfunction

    function automatic logic [WIDTH-1:0] rand_op();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            2:       return WIDTH'($urandom);
            default: return WIDTH'(1) << $urandom_range(0, WIDTH - 1);
        endcase
    endfunction

    // Model: advances the expected cycle on each edge, starting a trace when idle and start=1.
    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            exp_q.delete();
            exp_cur = '0;
        end else begin
            if (!exp_cur.busy && start) begin
                op_a = nxt_a;
                op_b = nxt_b;
                push_op(op_b);
            end
            if (exp_q.size() > 0) begin
                exp_cur = exp_q.pop_front();
            end else begin
                idle_e       = '0;
                idle_e.count = exp_cur.count;
                exp_cur      = idle_e;
            end
        end
    end

    // Compare every cycle, then advance the reference datapath from the DUT strobes.
    initial forever begin
        @(negedge clk);
        check("outputs", 64'({load, add_en, shift_en, busy, done, count}),
              64'({exp_cur.load, exp_cur.add_en, exp_cur.shift_en, exp_cur.busy,
                   exp_cur.done, exp_cur.count}));
        if (load) dp = {{(WIDTH + 1){1'b0}}, op_b};
        if (add_en) dp[2*WIDTH:WIDTH] = dp[2*WIDTH:WIDTH] + {1'b0, op_a};
        if (shift_en) dp = dp >> 1;
        if (done) begin
            last_prod = 64'(dp[2*WIDTH-1:0]);
            check("product", last_prod, 64'(op_a) * 64'(op_b));
        end
        mult_lsb = (exp_cur.is_test || !noise_en) ? dp[0] : 1'($urandom);
    end

    task automatic wait_done(input string tag, input int bound);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check({tag, "_timeout"}, 64'(0), 64'(1));
    endtask

    // One start pulse; measures latency in cycles (LOAD is cycle 1) and strobe counts.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input int want_lat, input int want_adds);
        int               lat;
        int               adds;
        int               shifts;
        int               loads;
        logic             prev_add;
        logic [WIDTH-1:0] mask;
        lat = 0; adds = 0; shifts = 0; loads = 0; prev_add = 1'b0; mask = '0;
        @(negedge clk);
        nxt_a = a;
        nxt_b = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            if (k > 1) @(negedge clk);
            if (prev_add) check({tag, "_add_then_shift"}, 64'(shift_en), 64'(1));
            loads    += int'(load);
            adds     += int'(add_en);
            shifts   += int'(shift_en);
            if (add_en) mask[count] = 1'b1;
            prev_add = add_en;
            if (done) begin
                lat = k;
                break;
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'(want_lat));
        check({tag, "_adds"}, 64'(adds), 64'(want_adds));
        check({tag, "_shifts"}, 64'(shifts), 64'(WIDTH));
        check({tag, "_loads"}, 64'(loads), 64'(1));
        check({tag, "_add_iters"}, 64'(mask), 64'(b));
        @(posedge clk);
    endtask

    initial begin
        int idle_cnt;
        int dones;
        bit hit;

        repeat (3) @(negedge clk);
        #1;
        check("por_outputs", 64'({load, add_en, shift_en, busy, done, count}), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_op("zero", 32'h0000_0003, 32'h0000_0000, 66, 0);
        check("zero_prod", last_prod, 64'h0);
        run_op("ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 98, 32);
        check("ones_prod", last_prod, 64'hFFFF_FFFE_0000_0001);
        run_op("five", 32'h0000_0003, 32'h0000_0005, 68, 2);
        check("five_prod", last_prod, 64'd15);

        // Back-to-back with start held high: exactly one idle cycle between operations.
        @(negedge clk);
        nxt_a = rand_op();
        nxt_b = rand_op();
        start = 1'b1;
        for (int op = 0; op < 3; op++) begin
            wait_done("b2b", 200);
            nxt_a = rand_op();
            nxt_b = rand_op();
            if (op == 2) begin
                start = 1'b0;
            end else begin
                idle_cnt = 0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    if (load) break;
                    if (!busy) idle_cnt++;
                end
                check("b2b_gap", 64'(idle_cnt), 64'(1));
            end
        end
        @(negedge clk);

        // Abort mid-operation at count 10 in SHIFT.
        nxt_a = 32'h1234_5678;
        nxt_b = 32'hA5A5_A5A5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit   = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (shift_en && count == CNT_W'(10)) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("abort_reached", 64'(hit), 64'(1));
        #2 reset = 1'b1;
        #1;
        check("abort_async", 64'({load, add_en, shift_en, busy, done, count}), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            dones += int'(done);
        end
        check("abort_no_done", 64'(dones), 64'(0));

        // start already high on release is taken at the first edge.
        reset = 1'b1;
        @(negedge clk);
        start = 1'b1;
        reset = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("release_load", 64'(load), 64'(1));
        wait_done("release", 200);
        @(negedge clk);

        // Random traffic: start toggles freely, mult_lsb is noisy outside TEST, rare resets.
        noise_en = 1'b1;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            nxt_a = rand_op();
            nxt_b = rand_op();
            if ($urandom_range(0, 999) == 0) begin
                #2 reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
        end
        start = 1'b0;
        repeat (110) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
